// File: rtl/viewport_fetch.sv
// Scrolling-background fetcher: scan pixel -> camera-relative ROM address -> colour.
// Fixed latency of ROM_LAT+3 cycles, one pixel per clock, no stalls.
module viewport_fetch #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 16,
    parameter int ROM_LAT = 1,
    parameter logic [COLOR_W-1:0] BORDER = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [X_W-1:0]     cx,
    input  logic [Y_W-1:0]     cy,
    input  logic [X_W-1:0]     posX,
    input  logic [Y_W-1:0]     posY,
    input  logic               wrap,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] ocolor,
    output logic               ocolor_valid
);

    localparam int SXW = X_W + 2;
    localparam int SYW = Y_W + 2;
    localparam logic signed [SXW-1:0] HALF_W = SXW'(SCR_W / 2);
    localparam logic signed [SYW-1:0] HALF_H = SYW'(SCR_H / 2);
    localparam logic signed [SXW-1:0] IMG_WS = SXW'(IMG_W);
    localparam logic signed [SYW-1:0] IMG_HS = SYW'(IMG_H);

    logic [X_W-1:0]     cam_x_q, cam_x_d;
    logic [Y_W-1:0]     cam_y_q, cam_y_d;
    logic               wrap_q, wrap_d;
    logic [SXW-1:0]     sx_q, sx_d;
    logic [SYW-1:0]     sy_q, sy_d;
    logic               v0_q, in0_q, inside_d;
    logic               v1_q, in1_q;
    logic [ROM_LAT-1:0] vpipe_q, ipipe_q;
    logic [ADDR_W-1:0]  rom_addr_q, addr_d;
    logic [COLOR_W-1:0] ocolor_q;
    logic               ocolor_valid_q;

    logic signed [SXW-1:0] sx_raw, sx_wrap;
    logic signed [SYW-1:0] sy_raw, sy_wrap;
    logic                  sx_lo, sx_hi, sy_lo, sy_hi;

    // A frame_start pixel already sees the new camera, so bypass the latch.
    always_comb begin
        cam_x_d  = frame_start ? posX : cam_x_q;
        cam_y_d  = frame_start ? posY : cam_y_q;
        wrap_d   = frame_start ? wrap : wrap_q;
        sx_raw   = $signed({2'b00, cam_x_d}) + $signed({2'b00, cx}) - HALF_W;
        sy_raw   = $signed({2'b00, cam_y_d}) + $signed({2'b00, cy}) - HALF_H;
        sx_lo    = sx_raw < 0;
        sx_hi    = sx_raw >= IMG_WS;
        sy_lo    = sy_raw < 0;
        sy_hi    = sy_raw >= IMG_HS;
        sx_wrap  = sx_lo ? sx_raw + IMG_WS : (sx_hi ? sx_raw - IMG_WS : sx_raw);
        sy_wrap  = sy_lo ? sy_raw + IMG_HS : (sy_hi ? sy_raw - IMG_HS : sy_raw);
        sx_d     = wrap_d ? sx_wrap : sx_raw;
        sy_d     = wrap_d ? sy_wrap : sy_raw;
        inside_d = wrap_d | (~sx_lo & ~sx_hi & ~sy_lo & ~sy_hi);
        addr_d   = ADDR_W'(sy_q) * ADDR_W'(IMG_W) + ADDR_W'(sx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cam_x_q        <= '0;
            cam_y_q        <= '0;
            wrap_q         <= 1'b0;
            sx_q           <= '0;
            sy_q           <= '0;
            v0_q           <= 1'b0;
            in0_q          <= 1'b0;
            v1_q           <= 1'b0;
            in1_q          <= 1'b0;
            vpipe_q        <= '0;
            ipipe_q        <= '0;
            rom_addr_q     <= '0;
            ocolor_q       <= '0;
            ocolor_valid_q <= 1'b0;
        end else begin
            cam_x_q    <= cam_x_d;
            cam_y_q    <= cam_y_d;
            wrap_q     <= wrap_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            v0_q       <= pix_valid;
            in0_q      <= inside_d;
            v1_q       <= v0_q;
            in1_q      <= in0_q;
            rom_addr_q <= in0_q ? addr_d : '0;
            vpipe_q[0] <= v1_q;
            ipipe_q[0] <= in1_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
                ipipe_q[i] <= ipipe_q[i-1];
            end
            if (vpipe_q[ROM_LAT-1]) begin
                ocolor_q <= ipipe_q[ROM_LAT-1] ? rom_data : BORDER;
            end
            ocolor_valid_q <= vpipe_q[ROM_LAT-1];
        end
    end

    assign rom_addr     = rom_addr_q;
    assign ocolor       = ocolor_q;
    assign ocolor_valid = ocolor_valid_q;

endmodule

// File: tb/tb_viewport_fetch.sv
// Bench for viewport_fetch: two instances (ROM_LAT 1 and 3) fed the same scan,
// table-driven vectors plus stream/gap and mid-stream reset sequences.
module tb_viewport_fetch;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs = 1'b0;
    logic        pv = 1'b0;
    logic        wr = 1'b0;
    logic [9:0]  cx = '0;
    logic [9:0]  posx = '0;
    logic [8:0]  cy = '0;
    logic [8:0]  posy = '0;
    logic [18:0] ra0, ra1;
    logic [15:0] rd0, rd1, oc0, oc1;
    logic        ov0, ov1;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          due;
        logic [18:0] addr;
    } aexp_t;

    typedef struct {
        int          due;
        logic [15:0] col;
    } cexp_t;

    typedef struct {
        bit f;
        int px;
        int py;
        bit w;
        int x;
        int y;
        int a;
        bit b;
    } vec_t;

    aexp_t       aq[$];
    cexp_t       cq[2][$];
    logic [15:0] last[2];
    vec_t        tbl[19];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_f(input logic [18:0] a);
        logic [31:0] v;
        v = {13'b0, a};
        return 16'((v * 32'd37) ^ (v >> 16) ^ 32'h0A5A);
    endfunction

    // ROM models with 1 and 3 cycles of read latency
    logic [15:0] p0 = '0;
    logic [15:0] p1[3] = '{default: '0};
    always @(posedge clk) begin
        p0    <= rom_f(ra0);
        p1[0] <= rom_f(ra1);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign rd0 = p0;
    assign rd1 = p1[2];

    viewport_fetch #(.ROM_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst), .frame_start(fs), .pix_valid(pv),
        .cx(cx), .cy(cy), .posX(posx), .posY(posy), .wrap(wr),
        .rom_addr(ra0), .rom_data(rd0), .ocolor(oc0), .ocolor_valid(ov0)
    );

    viewport_fetch #(.ROM_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst), .frame_start(fs), .pix_valid(pv),
        .cx(cx), .cy(cy), .posX(posx), .posY(posy), .wrap(wr),
        .rom_addr(ra1), .rom_data(rd1), .ocolor(oc1), .ocolor_valid(ov1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        aexp_t       ae;
        cexp_t       ce;
        logic [15:0] o;
        logic        v;
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            ae = aq.pop_front();
            chk("rom_addr_lat1", 32'(ra0), 32'(ae.addr));
            chk("rom_addr_lat3", 32'(ra1), 32'(ae.addr));
        end
        for (int d = 0; d < 2; d++) begin
            o = (d == 0) ? oc0 : oc1;
            v = (d == 0) ? ov0 : ov1;
            if (v) begin
                if (cq[d].size() == 0) begin
                    chk($sformatf("stale_valid%0d", d), 32'd1, 32'd0);
                end else begin
                    ce = cq[d].pop_front();
                    chk($sformatf("latency%0d", d), 32'(cyc), 32'(ce.due));
                    chk($sformatf("ocolor%0d", d), 32'(o), 32'(ce.col));
                    last[d] = ce.col;
                end
            end else begin
                if (cq[d].size() > 0 && cq[d][0].due <= cyc) begin
                    ce = cq[d].pop_front();
                    chk($sformatf("missing_valid%0d", d), 32'd0, 32'd1);
                end
                chk($sformatf("ocolor_hold%0d", d), 32'(o), 32'(last[d]));
            end
        end
    end

    task automatic drive(input bit f, input int px, input int py, input bit w,
                         input bit v, input int x, input int y,
                         input int a, input bit b);
        aexp_t ae;
        cexp_t ce;
        fs   = f;
        posx = 10'(px);
        posy = 9'(py);
        wr   = w;
        pv   = v;
        cx   = 10'(x);
        cy   = 9'(y);
        if (v) begin
            ae.due  = cyc + 2;
            ae.addr = 19'(a);
            aq.push_back(ae);
            ce.col  = b ? 16'hFFFF : rom_f(19'(a));
            ce.due  = cyc + 3 + LAT0;
            cq[0].push_back(ce);
            ce.due  = cyc + 3 + LAT1;
            cq[1].push_back(ce);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fs = 1'b0;
        pv = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fs  = 1'b0;
        pv  = 1'b0;
        aq.delete();
        cq[0].delete();
        cq[1].delete();
        last[0] = '0;
        last[1] = '0;
        #1;
        chk("rst_ocolor0", 32'(oc0), 32'd0);
        chk("rst_valid0", 32'(ov0), 32'd0);
        chk("rst_ocolor1", 32'(oc1), 32'd0);
        chk("rst_valid1", 32'(ov1), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        last[0] = '0;
        last[1] = '0;
        //        f  px   py   w  x    y    addr    border
        tbl = '{
            '{0, 0,    0,   0, 321, 241, 641,    0},
            '{1, 320,  240, 0, 0,   0,   0,      0},
            '{1, 400,  240, 0, 559, 240, 154239, 0},
            '{0, 400,  240, 0, 560, 240, 0,      1},
            '{1, 0,    240, 0, 319, 240, 0,      1},
            '{0, 0,    240, 0, 320, 240, 153600, 0},
            '{1, 320,  0,   0, 0,   239, 0,      1},
            '{0, 320,  0,   0, 0,   240, 0,      0},
            '{1, 320,  479, 0, 5,   240, 306565, 0},
            '{0, 320,  479, 0, 5,   241, 0,      1},
            '{1, 100,  100, 1, 0,   0,   218020, 0},
            '{1, 639,  479, 1, 639, 479, 152638, 0},
            '{1, 0,    0,   1, 0,   0,   153920, 0},
            '{1, 320,  240, 0, 0,   0,   0,      0},
            '{0, 330,  240, 0, 0,   0,   0,      0},
            '{0, 330,  240, 0, 639, 479, 307199, 0},
            '{1, 330,  240, 0, 0,   0,   10,     0},
            '{0, 0,    0,   1, 0,   0,   10,     0},
            '{1, 1000, 240, 0, 0,   0,   0,      1}
        };

        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr0", 32'(ra0), 32'd0);
        chk("reset_addr1", 32'(ra1), 32'd0);
        chk("reset_ocolor0", 32'(oc0), 32'd0);
        chk("reset_valid0", 32'(ov0), 32'd0);
        chk("reset_ocolor1", 32'(oc1), 32'd0);
        chk("reset_valid1", 32'(ov1), 32'd0);
        rst = 1'b0;
        idle(2);

        foreach (tbl[i]) begin
            drive(tbl[i].f, tbl[i].px, tbl[i].py, tbl[i].w, 1'b1,
                  tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].b);
        end
        idle(8);

        // stream of 8, gap of 3, then 2 more
        drive(1, 320, 240, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) drive(0, 320, 240, 0, 1, i, 0, i, 0);
        idle(3);
        drive(0, 320, 240, 0, 1, 600, 10, 7000, 0);
        drive(0, 320, 240, 0, 1, 601, 10, 7001, 0);
        idle(8);

        // reset with three pixels in flight
        for (int i = 1; i < 4; i++) drive(0, 320, 240, 0, 1, i, 0, i, 0);
        do_reset();
        idle(10);
        drive(1, 320, 240, 0, 1, 4, 2, 1284, 0);
        idle(10);

        chk("drain", 32'(cq[0].size() + cq[1].size() + aq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/viewport_fetch.md
Name: viewport_fetch

Overview:
- Pipelined scrolling-background pixel fetcher between the VGA scan counter and the background image ROM.
- For each scan pixel (cx, cy) it computes the source image coordinate from a camera position latched once per frame. It then issues a ROM address and returns the pixel colour, or a border colour, with a fixed latency.
- Generalises the earlier single-image colour lookup: image and screen sizes, colour width and ROM latency are parameters; wrap and clamp edge modes are supported; valid is tracked through the pipeline; the camera latch is tear-free.

Parameters:
- IMG_W, 640, source image width in pixels
- IMG_H, 480, source image height in pixels
- SCR_W, 640, visible screen width
- SCR_H, 480, visible screen height
- X_W, 10, width of x coordinates
- Y_W, 9, width of y coordinates
- ADDR_W, 19, ROM address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W
- COLOR_W, 16, pixel colour width
- ROM_LAT, 1, ROM read latency in clk cycles (1..4)
- BORDER, 16'hFFFF, colour output for out-of-image pixels in clamp mode

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of frame; latches posX/posY/wrap
- pix_valid  in  1  cx/cy are a visible pixel this cycle
- cx  in  X_W  scan x, 0..SCR_W-1
- cy  in  Y_W  scan y, 0..SCR_H-1
- posX  in  X_W  camera centre x in image space
- posY  in  Y_W  camera centre y in image space
- wrap  in  1  0 = clamp (border colour outside image), 1 = toroidal wrap
- rom_addr  out  ADDR_W  ROM address, registered
- rom_data  in  COLOR_W  ROM data, valid ROM_LAT cycles after rom_addr
- ocolor  out  COLOR_W  output colour, registered
- ocolor_valid  out  1  ocolor corresponds to a pix_valid input

Behaviour:
- Reset values: camera latches (camX, camY) = 0; wrap latch = 0; rom_addr = 0; ocolor = 0; ocolor_valid = 0; all pipeline valid/inside flags = 0.
- Reset is honoured mid-frame: the pipeline is flushed and no stale ocolor_valid appears after release.
- Camera latch: on a clk edge with frame_start = 1, capture posX, posY and wrap. posX/posY changes at any other time have no effect.
- If frame_start and pix_valid occur in the same cycle, that pixel already uses the new camera.
- Stage 0 (registered):
  - Signed source coordinates, width X_W+2 / Y_W+2: sx = camX + cx - SCR_W/2, sy = camY + cy - SCR_H/2.
  - Clamp mode: inside = (0 <= sx < IMG_W) and (0 <= sy < IMG_H).
  - Wrap mode: if sx < 0 add IMG_W; if sx >= IMG_W subtract IMG_W; same for sy with IMG_H; inside = 1.
  - A single correction is sufficient because camX < IMG_W and camY < IMG_H is required. Camera values outside that range are undefined in wrap mode only; clamp mode stays correct.
- Stage 1 (registered): rom_addr = sy*IMG_W + sx, truncated to ADDR_W; forced to 0 when inside = 0 (no out-of-range ROM access).
- Stages 2..1+ROM_LAT: valid and inside flags delayed by a shift register to align with rom_data.
- Output stage (registered):
  - If the aligned valid = 1: ocolor = inside ? rom_data : BORDER, and ocolor_valid = 1.
  - If the aligned valid = 0: ocolor holds its previous value and ocolor_valid = 0.
- Latency: pix_valid at edge n gives ocolor_valid at edge n + 3 + ROM_LAT. With ROM_LAT = 1 this is 4 cycles.
- Throughput is one pixel per clock, with no stalls. Back-to-back pix_valid produces back-to-back ocolor_valid.
- Gaps in pix_valid (blanking) propagate as gaps in ocolor_valid. rom_addr may change during gaps; this is harmless.
- Reaching the image edge in clamp mode switches to BORDER on exactly the first pixel with sx = IMG_W or sx = -1. There is no off-by-one.

Test Plan:
- Reset, then camera (320,240), wrap = 0, pix (0,0) -> rom_addr 0 one cycle after stage 0; ocolor = ROM[0] with ocolor_valid 4 cycles after pix_valid (ROM_LAT = 1).
- Clamp edge: camera (400,240), scan cx = 559 and cx = 560 at cy = 240 -> sx = 639 returns ROM[240*640+639]; sx = 640 returns BORDER 16'hFFFF with no ROM access (rom_addr 0).
- Wrap: camera (100,100), wrap = 1, pix (0,0) -> sx = -220 wraps to 420, sy = -140 wraps to 340; rom_addr = 340*640+420 = 218020.
- Tear-free latch: change posX from 320 to 330 mid-frame without frame_start -> output addresses unchanged. Pulse frame_start together with pix (0,0) -> that pixel uses camX = 330 (sx = 10).
- Stream and gaps: 8 consecutive pix_valid, 3 idle, 2 more -> ocolor_valid shows the same 8-3-2 pattern delayed by 4 cycles; ocolor holds its value during the gap.
- Mid-stream reset: assert rst with 3 pixels in flight -> ocolor = 0 and ocolor_valid = 0 immediately; no ocolor_valid pulses after release until new pix_valid arrives; re-run with ROM_LAT = 3 -> latency 6.
